// File: rtl/irig_b_pkg.sv
// Shared types and constants for the IRIG-B (B00x) timecode generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package irig_b_pkg;

   typedef enum logic [1:0] {
      BK_ZERO,
      BK_ONE,
      BK_MARK
   } bit_kind_t;

   localparam int FRAME_BITS = 100;
   localparam int BIT_MS     = 10;
   localparam int ZERO_MS    = 2;
   localparam int ONE_MS     = 5;
   localparam int MARK_MS    = 8;

   // Field start positions inside the frame; every field is sent LSB first.
   localparam int SEC_U_POS  = 1;
   localparam int SEC_T_POS  = 6;
   localparam int MIN_U_POS  = 10;
   localparam int MIN_T_POS  = 15;
   localparam int HOUR_U_POS = 20;
   localparam int HOUR_T_POS = 25;
   localparam int DAY_U_POS  = 30;
   localparam int DAY_T_POS  = 35;
   localparam int DAY_H_POS  = 40;
   localparam int SBS_LO_POS = 80;
   localparam int SBS_HI_POS = 90;

   typedef struct packed {
      logic [9:0] doy;
      logic [5:0] hour;
      logic [6:0] min;
      logic [6:0] sec;
   } bcd_time_t;

   // Marker set: Pr at bit 0, P1..P9 and P0 at every bit ending in 9.
   function automatic logic is_marker(input logic [6:0] idx);
      case (idx)
         7'd0, 7'd9, 7'd19, 7'd29, 7'd39, 7'd49,
         7'd59, 7'd69, 7'd79, 7'd89, 7'd99: is_marker = 1'b1;
         default:                           is_marker = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] high_ms(input bit_kind_t kind);
      case (kind)
         BK_ONE:  high_ms = 4'(ONE_MS);
         BK_MARK: high_ms = 4'(MARK_MS);
         default: high_ms = 4'(ZERO_MS);
      endcase
   endfunction

   // Up to three BCD digits to binary.
   function automatic int bcd_to_bin(input logic [11:0] bcd);
      bcd_to_bin = int'(bcd[11:8]) * 100 + int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
   endfunction

endpackage

// File: rtl/irig_b_time_cnt.sv
// BCD time-of-day / day-of-year counters with pending-load register; optional SBS counter (IRIG_GEN_SBS_EN).
// Latency: cur_time/sbs update on the edge where apply is high (load applied, else increment if inc).
// Backpressure: none; load is a strobe and overwrites any load not yet applied.
module irig_b_time_cnt
   import irig_b_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  bcd_time_t  load_time,
   input  logic       apply,
   input  logic       inc,
`ifdef IRIG_GEN_SBS_EN
   output logic [16:0] sbs,
`endif
   output bcd_time_t  cur_time
);

   bcd_time_t pend_time;
   bcd_time_t eff_time;
   bcd_time_t inc_time;
   logic      pend_vld;
   logic      sec_wrap;
   logic      min_wrap;
   logic      hour_wrap;
   logic      day_roll;

   // A load arriving on the frame-start edge wins over an older pending value.
   assign eff_time = load ? load_time : pend_time;

   assign sec_wrap  = (cur_time.sec == 7'h59);
   assign min_wrap  = (cur_time.min == 7'h59);
   assign hour_wrap = (cur_time.hour == 6'h23);
   assign day_roll  = sec_wrap & min_wrap & hour_wrap;

   // One-second BCD increment with carries sec->min->hour->day, day 365 wraps to 001.
   always_comb begin
      inc_time = cur_time;
      if (sec_wrap)
         inc_time.sec = 7'h00;
      else if (cur_time.sec[3:0] == 4'd9)
         inc_time.sec = {cur_time.sec[6:4] + 3'd1, 4'd0};
      else
         inc_time.sec[3:0] = cur_time.sec[3:0] + 4'd1;

      if (sec_wrap) begin
         if (min_wrap)
            inc_time.min = 7'h00;
         else if (cur_time.min[3:0] == 4'd9)
            inc_time.min = {cur_time.min[6:4] + 3'd1, 4'd0};
         else
            inc_time.min[3:0] = cur_time.min[3:0] + 4'd1;
      end

      if (sec_wrap && min_wrap) begin
         if (hour_wrap)
            inc_time.hour = 6'h00;
         else if (cur_time.hour[3:0] == 4'd9)
            inc_time.hour = {cur_time.hour[5:4] + 2'd1, 4'd0};
         else
            inc_time.hour[3:0] = cur_time.hour[3:0] + 4'd1;
      end

      if (day_roll) begin
         if (cur_time.doy == 10'h365)
            inc_time.doy = 10'h001;
         else if (cur_time.doy[3:0] != 4'd9)
            inc_time.doy[3:0] = cur_time.doy[3:0] + 4'd1;
         else if (cur_time.doy[7:4] != 4'd9)
            inc_time.doy = {cur_time.doy[9:8], cur_time.doy[7:4] + 4'd1, 4'd0};
         else
            inc_time.doy = {cur_time.doy[9:8] + 2'd1, 8'h00};
      end
   end

   // Pending-load capture and frame-start update of the current time.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_time  <= '{doy: 10'h001, hour: 6'h00, min: 7'h00, sec: 7'h00};
         pend_time <= '0;
         pend_vld  <= 1'b0;
      end else begin
         if (load) begin
            pend_time <= load_time;
            pend_vld  <= 1'b1;
         end
         if (apply) begin
            if (load || pend_vld) begin
               cur_time <= eff_time;
               pend_vld <= 1'b0;
            end else if (inc) begin
               cur_time <= inc_time;
            end
         end
      end
   end

`ifdef IRIG_GEN_SBS_EN
   logic [16:0] load_sbs;

   assign load_sbs = 17'(bcd_to_bin(12'(eff_time.hour)) * 3600 +
                         bcd_to_bin(12'(eff_time.min)) * 60 +
                         bcd_to_bin(12'(eff_time.sec)));

   // Seconds-of-day counter; recomputed from BCD on load, wraps with midnight.
   always_ff @(posedge clk) begin
      if (rst) begin
         sbs <= '0;
      end else if (apply) begin
         if (load || pend_vld)
            sbs <= load_sbs;
         else if (inc)
            sbs <= day_roll ? 17'd0 : sbs + 17'd1;
      end
   end
`endif

endmodule

// File: rtl/irig_b_gen.sv
// IRIG-B DC level-shift frame generator (100 bit/s, BCD time + day; SBS field when IRIG_GEN_SBS_EN is defined).
// Latency: irig_out rises one cycle after en is first sampled high; all outputs registered.
// Backpressure: none; en low forces output low and holds time, restart always begins at bit 0.
module irig_b_gen
   import irig_b_pkg::*;
#(
   parameter int TICKS_PER_MS = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  logic [6:0] load_sec,
   input  logic [6:0] load_min,
   input  logic [5:0] load_hour,
   input  logic [9:0] load_doy,
   output logic       irig_out,
   output logic       frame_start,
   output logic [6:0] bit_idx
);

   localparam int TW = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HIGH,
      S_LOW
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [TW-1:0]   tick;
   logic [TW-1:0]   tick_nxt;
   logic [3:0]      ms;
   logic [3:0]      ms_nxt;
   logic [6:0]      bit_nxt;
   logic            start;
   logic            inc;
   logic            tick_last;
   bcd_time_t       cur_time;
   bcd_time_t       load_time;
   logic [FRAME_BITS-1:0] frame_bits;
   bit_kind_t       kind;

   assign load_time = '{doy: load_doy, hour: load_hour, min: load_min, sec: load_sec};

`ifdef IRIG_GEN_SBS_EN
   logic [16:0] sbs;
`endif

   irig_b_time_cnt u_time_cnt (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_time (load_time),
      .apply     (start),
      .inc       (inc),
`ifdef IRIG_GEN_SBS_EN
      .sbs       (sbs),
`endif
      .cur_time  (cur_time)
   );

   // Data-bit image of the frame; cur_time only changes on frame start so the frame never tears.
   always_comb begin
      frame_bits = '0;
      frame_bits[SEC_U_POS  +: 4] = cur_time.sec[3:0];
      frame_bits[SEC_T_POS  +: 3] = cur_time.sec[6:4];
      frame_bits[MIN_U_POS  +: 4] = cur_time.min[3:0];
      frame_bits[MIN_T_POS  +: 3] = cur_time.min[6:4];
      frame_bits[HOUR_U_POS +: 4] = cur_time.hour[3:0];
      frame_bits[HOUR_T_POS +: 2] = cur_time.hour[5:4];
      frame_bits[DAY_U_POS  +: 4] = cur_time.doy[3:0];
      frame_bits[DAY_T_POS  +: 4] = cur_time.doy[7:4];
      frame_bits[DAY_H_POS  +: 2] = cur_time.doy[9:8];
`ifdef IRIG_GEN_SBS_EN
      frame_bits[SBS_LO_POS +: 9] = sbs[8:0];
      frame_bits[SBS_HI_POS +: 8] = sbs[16:9];
`endif
   end

   // Bit-kind mux for the bit currently being sent.
   always_comb begin
      kind = BK_ZERO;
      if (is_marker(bit_idx))
         kind = BK_MARK;
      else if (frame_bits[bit_idx])
         kind = BK_ONE;
   end

   assign tick_last = (tick == TW'(TICKS_PER_MS - 1));

   // Next-state, ms/tick counters and bit advance; en low always returns to idle.
   always_comb begin
      state_nxt = state;
      tick_nxt  = tick;
      ms_nxt    = ms;
      bit_nxt   = bit_idx;
      start     = 1'b0;
      inc       = 1'b0;
      if (!en) begin
         state_nxt = S_IDLE;
         tick_nxt  = '0;
         ms_nxt    = '0;
         bit_nxt   = '0;
      end else begin
         case (state)
            S_IDLE: begin
               state_nxt = S_HIGH;
               tick_nxt  = '0;
               ms_nxt    = '0;
               bit_nxt   = '0;
               start     = 1'b1;
            end
            S_HIGH: begin
               if (tick_last) begin
                  tick_nxt = '0;
                  ms_nxt   = ms + 4'd1;
                  if (ms + 4'd1 == high_ms(kind))
                     state_nxt = S_LOW;
               end else begin
                  tick_nxt = tick + TW'(1);
               end
            end
            S_LOW: begin
               if (tick_last) begin
                  tick_nxt = '0;
                  if (ms == 4'(BIT_MS - 1)) begin
                     ms_nxt    = '0;
                     state_nxt = S_HIGH;
                     if (bit_idx == 7'(FRAME_BITS - 1)) begin
                        bit_nxt = '0;
                        start   = 1'b1;
                        inc     = 1'b1;
                     end else begin
                        bit_nxt = bit_idx + 7'd1;
                     end
                  end else begin
                     ms_nxt = ms + 4'd1;
                  end
               end else begin
                  tick_nxt = tick + TW'(1);
               end
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State/counter registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         tick        <= '0;
         ms          <= '0;
         bit_idx     <= '0;
         irig_out    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nxt;
         tick        <= tick_nxt;
         ms          <= ms_nxt;
         bit_idx     <= bit_nxt;
         irig_out    <= (state_nxt == S_HIGH);
         frame_start <= start;
      end
   end

endmodule

// File: tb/tb_irig_b_gen.sv
// Self-checking bench for irig_b_gen at TICKS_PER_MS=4 (bit = 40 cycles, frame = 4000 cycles).
// Latency: n/a.
// Backpressure: n/a.
module tb_irig_b_gen;

   localparam int T      = 4;
   localparam int BITC   = 10 * T;
   localparam int FRAMEC = 100 * BITC;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       load;
   logic [6:0] load_sec;
   logic [6:0] load_min;
   logic [5:0] load_hour;
   logic [9:0] load_doy;
   logic       irig_out;
   logic       frame_start;
   logic [6:0] bit_idx;

   irig_b_gen #(.TICKS_PER_MS(T)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .load        (load),
      .load_sec    (load_sec),
      .load_min    (load_min),
      .load_hour   (load_hour),
      .load_doy    (load_doy),
      .irig_out    (irig_out),
      .frame_start (frame_start),
      .bit_idx     (bit_idx)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: integer time, per-bit high time in ms, position within frame.
   int m_s = 0, m_m = 0, m_h = 0, m_d = 1;
   int p_s = 0, p_m = 0, p_h = 0, p_d = 1;
   bit m_pend = 1'b0;
   bit m_run  = 1'b0;
   int m_pos  = 0;
   int m_idx  = 0;
   int m_hi[100];
   logic m_out = 1'b0;
   logic m_fs  = 1'b0;

   // Observed high cycles per bit, for the current and the last completed frame.
   int hw[100];
   int hw_last[100];
   int fs_count = 0;
   int cyc = 0;
   int last_fs_cyc = 0;
   int fs_gap = 0;

   int time_bits[30] = '{1, 2, 3, 4, 6, 7, 8, 10, 11, 12, 13, 15, 16, 17, 20, 21,
                         22, 23, 25, 26, 30, 31, 32, 33, 35, 36, 37, 38, 40, 41};

   function automatic int dec2(input int v);
      return ((v >> 4) & 15) * 10 + (v & 15);
   endfunction

   function automatic int dec3(input int v);
      return ((v >> 8) & 15) * 100 + ((v >> 4) & 15) * 10 + (v & 15);
   endfunction

   task automatic put_field(input int pos, input int val, input int n);
      for (int i = 0; i < n; i++)
         if (((val >> i) & 1) == 1) m_hi[pos + i] = 5;
   endtask

   task automatic new_frame(input bit adv);
      int sbs;
      if (adv) begin
         m_s++;
         if (m_s == 60) begin
            m_s = 0; m_m++;
            if (m_m == 60) begin
               m_m = 0; m_h++;
               if (m_h == 24) begin
                  m_h = 0;
                  m_d = (m_d == 365) ? 1 : m_d + 1;
               end
            end
         end
      end
      if (m_pend) begin
         m_s = p_s; m_m = p_m; m_h = p_h; m_d = p_d;
         m_pend = 1'b0;
      end
      for (int i = 0; i < 100; i++)
         m_hi[i] = (i == 0 || (i % 10) == 9) ? 8 : 2;
      put_field(1,  m_s % 10, 4);
      put_field(6,  m_s / 10, 3);
      put_field(10, m_m % 10, 4);
      put_field(15, m_m / 10, 3);
      put_field(20, m_h % 10, 4);
      put_field(25, m_h / 10, 2);
      put_field(30, m_d % 10, 4);
      put_field(35, (m_d / 10) % 10, 4);
      put_field(40, m_d / 100, 2);
      sbs = m_h * 3600 + m_m * 60 + m_s;
`ifdef IRIG_GEN_SBS_EN
      put_field(80, sbs & 511, 9);
      put_field(90, sbs >> 9, 8);
`endif
   endtask

   task automatic model_step();
      if (rst) begin
         m_run = 1'b0; m_pos = 0; m_pend = 1'b0;
         m_s = 0; m_m = 0; m_h = 0; m_d = 1;
         m_out = 1'b0; m_fs = 1'b0; m_idx = 0;
      end else begin
         m_fs = 1'b0;
         if (load) begin
            p_s = dec2(int'(load_sec)); p_m = dec2(int'(load_min));
            p_h = dec2(int'(load_hour)); p_d = dec3(int'(load_doy));
            m_pend = 1'b1;
         end
         if (!en) begin
            m_run = 1'b0;
            m_out = 1'b0;
         end else begin
            if (!m_run) begin
               m_run = 1'b1;
               m_pos = 0;
               new_frame(1'b0);
            end else begin
               m_pos++;
               if (m_pos == FRAMEC) begin
                  m_pos = 0;
                  new_frame(1'b1);
               end
            end
            m_idx = m_pos / BITC;
            m_out = ((m_pos % BITC) < m_hi[m_idx] * T);
            m_fs  = (m_pos == 0);
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Per-cycle comparison against the model, plus pulse-width bookkeeping.
   initial begin
      for (int i = 0; i < 100; i++) begin hw[i] = 0; hw_last[i] = 0; end
      forever begin
         @(negedge clk);
         cyc++;
         n_cmp++;
         if (irig_out !== m_out || frame_start !== m_fs ||
             (m_run && bit_idx !== 7'(m_idx))) begin
            n_err++;
            if (n_err <= 20)
               $display("FAIL cycle_compare cyc=%0d: irig_out=%b frame_start=%b bit_idx=%0d, model wants %b %b %0d",
                        cyc, irig_out, frame_start, bit_idx, m_out, m_fs, m_idx);
         end
         if (frame_start === 1'b1) begin
            fs_gap = cyc - last_fs_cyc;
            last_fs_cyc = cyc;
            fs_count++;
            for (int i = 0; i < 100; i++) begin hw_last[i] = hw[i]; hw[i] = 0; end
         end
         if (irig_out === 1'b1 && bit_idx < 7'd100)
            hw[bit_idx]++;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_fs(input int budget);
      int target;
      int k;
      target = fs_count + 1;
      k = 0;
      while (fs_count < target && k < budget) begin
         step(1);
         k++;
      end
      if (fs_count < target) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_frame_start: no frame_start within %0d cycles", budget);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; load = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   task automatic set_load(input logic [6:0] s, input logic [6:0] m,
                           input logic [5:0] h, input logic [9:0] d);
      load_sec = s; load_min = m; load_hour = h; load_doy = d;
      load = 1'b1;
   endtask

   task automatic check_midnight(input string tag);
      for (int i = 0; i < 30; i++)
         chk($sformatf("%s_bit%0d", tag, time_bits[i]), hw_last[time_bits[i]],
             (time_bits[i] == 30) ? 20 : 8);
   endtask

   initial begin
      int rb_idx[21] = '{1, 2, 3, 4, 6, 7, 8, 20, 21, 22, 25, 26, 30, 31, 32, 35, 36, 37, 38, 40, 41};
      int rb_exp[21] = '{20, 8, 8, 20, 20, 8, 20, 20, 20, 8, 8, 20, 20, 8, 20, 8, 20, 20, 8, 20, 20};
      logic [16:0] sbs_exp;
      int sb;

      rst = 1'b1; en = 1'b0; load = 1'b0;
      load_sec = '0; load_min = '0; load_hour = '0; load_doy = '0;
      step(3);
      chk("reset_irig_out", int'(irig_out), 0);
      chk("reset_frame_start", int'(frame_start), 0);
      chk("reset_bit_idx", int'(bit_idx), 0);
      rst = 1'b0;
      step(2);
      chk("idle_irig_out", int'(irig_out), 0);

      // Free run from reset time 00:00:00 day 001.
      en = 1'b1;
      step(1);
      chk("first_rise", int'(irig_out), 1);
      chk("first_frame_start", int'(frame_start), 1);
      step(1);
      wait_fs(FRAMEC + 10);
      chk("free_bit0_high", hw_last[0], 32);
      chk("free_bit1_high", hw_last[1], 8);
      chk("free_bit9_high", hw_last[9], 32);
      chk("free_bit99_high", hw_last[99], 32);
      chk("free_bit30_high", hw_last[30], 20);
      chk("free_frame_gap", fs_gap, FRAMEC);
      en = 1'b0;
      step(1);
      chk("free_en_drop", int'(irig_out), 0);

      // Rollover: 23:59:59 day 365, loaded on the en rise.
      do_reset();
      set_load(7'h59, 7'h59, 6'h23, 10'h365);
      en = 1'b1;
      step(1);
      load = 1'b0;
      step(1);
      wait_fs(FRAMEC + 10);
      for (int i = 0; i < 21; i++)
         chk($sformatf("roll_f1_bit%0d", rb_idx[i]), hw_last[rb_idx[i]], rb_exp[i]);
      wait_fs(FRAMEC + 10);
      check_midnight("roll_f2");
      en = 1'b0;

      // SBS field with 12:00:00.
      do_reset();
      set_load(7'h00, 7'h00, 6'h12, 10'h001);
      en = 1'b1;
      step(1);
      load = 1'b0;
      step(1);
      wait_fs(FRAMEC + 10);
      chk("sbs_hour_u_bit21", hw_last[21], 20);
      chk("sbs_hour_t_bit25", hw_last[25], 20);
      sbs_exp = 17'd43200;
      for (int k = 80; k <= 97; k++) begin
         if (k != 89) begin
            sb = (k < 89) ? k - 80 : k - 81;
`ifdef IRIG_GEN_SBS_EN
            chk($sformatf("sbs_bit%0d", k), hw_last[k], sbs_exp[sb] ? 20 : 8);
`else
            chk($sformatf("sbs_bit%0d", k), hw_last[k], 8);
`endif
         end
      end
      en = 1'b0;

      // Enable abort during bit 37, then restart with unchanged seconds (05).
      do_reset();
      set_load(7'h05, 7'h00, 6'h00, 10'h001);
      en = 1'b1;
      step(1);
      load = 1'b0;
      step(1);
      step(37 * BITC + 5);
      chk("abort_at_bit", int'(bit_idx), 37);
      en = 1'b0;
      step(1);
      chk("abort_out_low", int'(irig_out), 0);
      step(20);
      en = 1'b1;
      step(2);
      step(5 * BITC);
      chk("restart_bit0", hw[0], 32);
      chk("restart_bit1", hw[1], 20);
      chk("restart_bit2", hw[2], 8);
      chk("restart_bit3", hw[3], 20);
      chk("restart_bit4", hw[4], 8);
      en = 1'b0;

      // Mid-frame reset at bit 55 while sending 10:20:30.
      do_reset();
      set_load(7'h30, 7'h20, 6'h10, 10'h001);
      en = 1'b1;
      step(1);
      load = 1'b0;
      step(1);
      step(55 * BITC + 5);
      chk("rst_at_bit", int'(bit_idx), 55);
      rst = 1'b1;
      step(1);
      chk("rst_irig_out", int'(irig_out), 0);
      chk("rst_frame_start", int'(frame_start), 0);
      chk("rst_bit_idx", int'(bit_idx), 0);
      rst = 1'b0;
      step(2);
      wait_fs(FRAMEC + 10);
      check_midnight("after_rst");
      en = 1'b0;

      // Load 01:02:03 during bit 50: applies to the next frame only.
      do_reset();
      en = 1'b1;
      step(2);
      step(50 * BITC + 5);
      set_load(7'h03, 7'h02, 6'h01, 10'h001);
      step(1);
      load = 1'b0;
      wait_fs(FRAMEC + 10);
      check_midnight("old_frame");
      wait_fs(FRAMEC + 10);
      chk("new_bit1", hw_last[1], 20);
      chk("new_bit2", hw_last[2], 20);
      chk("new_bit3", hw_last[3], 8);
      chk("new_bit10", hw_last[10], 8);
      chk("new_bit11", hw_last[11], 20);
      chk("new_bit20", hw_last[20], 20);
      chk("new_bit21", hw_last[21], 8);
      chk("new_bit30", hw_last[30], 20);
      en = 1'b0;
      step(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
